// File: rtl/cpu_mem_pkg.sv
// Shared MEM data-port definitions: size encodings, responder states and the
// alignment check that MEM also uses for exception detection.
package cpu_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } dmem_req_t;

    // Size 3 is treated as misaligned so MEM and the responder flag it identically.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return lo[0];
            SIZE_W:  return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM data-port bundle: MEM is the master, dmem_responder is the slave.
interface dmem_responder_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );

endinterface

// File: rtl/dmem_responder_bwe_ram.sv
// Word-addressed data RAM with per-byte-lane write enables and combinational read.
// Each lane is a separate byte array so lanes never share a write process.
module bwe_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [2**ADDR_W];

        always_ff @(posedge clk) begin
            if (we[i]) mem[addr] <= wdata[8*i +: 8];
        end

        assign rdata[8*i +: 8] = mem[addr];
    end

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one request, waits LATENCY cycles,
// then commits the store or returns the raw aligned word with a one-cycle data_ok.
module dmem_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    dmem_req_t   lat_q;
    logic [31:0] rdata_q;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_we;
    logic        accept;
    logic        bad;
    logic        fire;
    logic        unused_addr_hi;

    assign accept = bus.req && (state == IDLE);
    assign bad    = misaligned(lat_q.size, lat_q.addr[1:0]);
    // A reset landing on the RESP cycle must suppress both the write and data_ok.
    assign fire   = (state == RESP) && !reset;

    // Upper address bits alias onto the RAM and are deliberately dropped.
    assign unused_addr_hi = ^lat_q.addr[31:ADDR_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (fire && !lat_q.wr && !bad) rdata_q <= ram_rdata;
        end
    end

    // Request fields need no reset: they are only consumed after a fresh acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_q <= '{wr:    bus.wr,
                       size:  bus.size,
                       addr:  bus.addr,
                       wstrb: bus.wstrb,
                       wdata: bus.wdata};
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        ram_we      = '0;
        bus.addr_ok = 1'b0;
        bus.data_ok = 1'b0;
        bus.err     = 1'b0;
        bus.rdata   = rdata_q;
        case (state)
            IDLE: begin
                bus.addr_ok = 1'b1;
                if (bus.req) begin
                    cnt_nx   = CNT_LOAD;
                    state_nx = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt_nx == 4'd0) state_nx = RESP;
            end
            RESP: begin
                state_nx = IDLE;
                if (fire) begin
                    bus.data_ok = 1'b1;
                    bus.err     = bad;
                    if (!bad) begin
                        if (lat_q.wr) ram_we    = lat_q.wstrb;
                        else          bus.rdata = ram_rdata;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    bwe_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (lat_q.addr[ADDR_W+1:2]),
        .wdata (lat_q.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 2, 1, 15) share stimulus,
// one is selected at a time; table vectors, corner sequences and a random phase.
module tb_dmem_responder;
    import cpu_mem_pkg::*;

    localparam int AW = 10;
    localparam int NW = 1 << AW;
    localparam logic [31:0] MALL = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    int          sel;
    logic        addr_ok_m, data_ok_m, err_m;
    logic [31:0] rdata_m;
    int          total = 0;
    int          bad = 0;
    int          lat_of [3] = '{2, 1, 15};

    dmem_responder_if bus0 ();
    dmem_responder_if bus1 ();
    dmem_responder_if bus2 ();

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.wr = wr;       assign bus1.wr = wr;       assign bus2.wr = wr;
    assign bus0.size = size;   assign bus1.size = size;   assign bus2.size = size;
    assign bus0.addr = addr;   assign bus1.addr = addr;   assign bus2.addr = addr;
    assign bus0.wstrb = wstrb; assign bus1.wstrb = wstrb; assign bus2.wstrb = wstrb;
    assign bus0.wdata = wdata; assign bus1.wdata = wdata; assign bus2.wdata = wdata;

    dmem_responder #(.ADDR_W(AW), .LATENCY(2))  dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_responder #(.ADDR_W(AW), .LATENCY(1))  dut1 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_responder #(.ADDR_W(AW), .LATENCY(15)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always_comb begin
        case (sel)
            1: {addr_ok_m, data_ok_m, err_m, rdata_m} = {bus1.addr_ok, bus1.data_ok, bus1.err, bus1.rdata};
            2: {addr_ok_m, data_ok_m, err_m, rdata_m} = {bus2.addr_ok, bus2.data_ok, bus2.err, bus2.rdata};
            default: {addr_ok_m, data_ok_m, err_m, rdata_m} = {bus0.addr_ok, bus0.data_ok, bus0.err, bus0.rdata};
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                       input logic [31:0] mask);
        total++;
        if (((act ^ exp) & mask) !== 32'd0) begin
            bad++;
            $display("FAIL %s dut%0d: got %h want %h (mask %h) at %0t", nm, sel, act, exp, mask, $time);
        end
    endtask

    task automatic select(input int s);
        sel = s;
        #1;
    endtask

    // Called just after a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic txn(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [3:0] sb, input logic [31:0] d,
                       output logic e, output logic [31:0] rd);
        int n;
        bit busy_ok;
        req = 1'b1; wr = w; size = sz; addr = a; wstrb = sb; wdata = d;
        n = 0;
        while (!addr_ok_m && n < 40) begin @(negedge clk); n++; end
        chk("accept_wait", 32'(n < 40), 32'd1, MALL);
        @(negedge clk);
        // Junk on the inputs after acceptance must be ignored.
        req = 1'(($urandom_range(0, 1)));
        wr = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3));
        addr = $urandom; wstrb = 4'($urandom_range(0, 15)); wdata = $urandom;
        n = 1;
        busy_ok = 1'b1;
        while (!data_ok_m && n < 40) begin
            if (addr_ok_m || err_m) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat_of[sel]), MALL);
        chk("busy_outs", 32'(busy_ok), 32'd1, MALL);
        chk("addr_ok_resp", 32'(addr_ok_m), 32'd0, MALL);
        e = err_m;
        rd = rdata_m;
        req = 1'b0;
        @(negedge clk);
        chk("data_ok_pulse", 32'(data_ok_m), 32'd0, MALL);
        chk("err_idle", 32'(err_m), 32'd0, MALL);
        chk("addr_ok_idle", 32'(addr_ok_m), 32'd1, MALL);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [3:0]  sb;
        logic [31:0] d;
        logic        e;
        logic [31:0] rd;
    } vec_t;

    vec_t tv [12];

    logic [7:0] mdat [3][NW][4];
    bit         mvld [3][NW][4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        e;
        logic [31:0] rd;

        tv[0]  = '{1'b1, SIZE_W, 32'h10,   4'hF,    32'hDEADBEEF, 1'b0, 32'h0};
        tv[1]  = '{1'b0, SIZE_W, 32'h10,   4'h0,    32'h0,        1'b0, 32'hDEADBEEF};
        tv[2]  = '{1'b1, SIZE_W, 32'h20,   4'hF,    32'h11223344, 1'b0, 32'hDEADBEEF};
        tv[3]  = '{1'b1, SIZE_B, 32'h22,   4'b0100, 32'hAAAAAAAA, 1'b0, 32'hDEADBEEF};
        tv[4]  = '{1'b0, SIZE_W, 32'h20,   4'h0,    32'h0,        1'b0, 32'h11AA3344};
        tv[5]  = '{1'b0, SIZE_H, 32'h21,   4'h0,    32'h0,        1'b1, 32'h11AA3344};
        tv[6]  = '{1'b1, SIZE_W, 32'h22,   4'hF,    32'h55667788, 1'b1, 32'h11AA3344};
        tv[7]  = '{1'b0, SIZE_W, 32'h20,   4'h0,    32'h0,        1'b0, 32'h11AA3344};
        tv[8]  = '{1'b0, 2'd3,   32'h20,   4'h0,    32'h0,        1'b1, 32'h11AA3344};
        tv[9]  = '{1'b1, SIZE_W, 32'h30,   4'h0,    32'h12345678, 1'b0, 32'h11AA3344};
        tv[10] = '{1'b0, SIZE_H, 32'h12,   4'h0,    32'h0,        1'b0, 32'hDEADBEEF};
        tv[11] = '{1'b0, SIZE_W, 32'h1010, 4'h0,    32'h0,        1'b0, 32'hDEADBEEF};

        req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wstrb = '0; wdata = '0;
        sel = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("rst_addr_ok", 32'(addr_ok_m), 32'd1, MALL);
            chk("rst_data_ok", 32'(data_ok_m), 32'd0, MALL);
            chk("rst_err", 32'(err_m), 32'd0, MALL);
            chk("rst_rdata", rdata_m, 32'd0, MALL);
        end

        // Directed vectors on the LATENCY=2 instance
        for (int i = 0; i < 12; i++) begin
            txn(tv[i].w, tv[i].sz, tv[i].a, tv[i].sb, tv[i].d, e, rd);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].e), MALL);
            chk($sformatf("vec%0d_rdata", i), rd, tv[i].rd, MALL);
        end

        // Back-to-back loads with req held high
        begin
            int acc[$];
            int dok[$];
            int l;
            l = lat_of[0];
            req = 1'b1; wr = 1'b0; size = SIZE_W; addr = 32'h10; wstrb = '0; wdata = '0;
            #1;
            for (int c = 0; c < 3 * (l + 1) + 3; c++) begin
                if (acc.size() == 3) req = 1'b0;
                if (addr_ok_m && req) acc.push_back(c);
                if (data_ok_m) begin
                    dok.push_back(c);
                    chk("b2b_rdata", rdata_m, 32'hDEADBEEF, MALL);
                end
                @(negedge clk);
                #1;
            end
            req = 1'b0;
            chk("b2b_acc_count", 32'(acc.size()), 32'd3, MALL);
            chk("b2b_dok_count", 32'(dok.size()), 32'd3, MALL);
            if (acc.size() == 3) begin
                chk("b2b_space1", 32'(acc[1] - acc[0]), 32'(l + 1), MALL);
                chk("b2b_space2", 32'(acc[2] - acc[1]), 32'(l + 1), MALL);
            end
            if (acc.size() == 3 && dok.size() == 3)
                for (int k = 0; k < 3; k++)
                    chk("b2b_dok_pos", 32'(dok[k] - acc[k]), 32'(l), MALL);
            @(negedge clk);
        end

        // Reset during an in-flight store, on every latency
        for (int s = 0; s < 3; s++) begin
            logic [31:0] oldv, newv;
            int ghost;
            oldv = 32'hA0A0_0000 | 32'(s);
            newv = 32'h5F5F_FFFF ^ 32'(s);
            select(s);
            txn(1'b1, SIZE_W, 32'h40, 4'hF, oldv, e, rd);
            req = 1'b1; wr = 1'b1; size = SIZE_W; addr = 32'h40; wstrb = 4'hF; wdata = newv;
            @(negedge clk);
            req = 1'b0;
            reset = 1'b1;
            #1;
            chk("abort_data_ok", 32'(data_ok_m), 32'd0, MALL);
            @(negedge clk);
            reset = 1'b0;
            #1;
            chk("abort_addr_ok", 32'(addr_ok_m), 32'd1, MALL);
            ghost = 0;
            for (int i = 0; i < 20; i++) begin
                if (data_ok_m) ghost++;
                @(negedge clk);
            end
            chk("abort_ghost", 32'(ghost), 32'd0, MALL);
            txn(1'b0, SIZE_W, 32'h40, 4'h0, 32'h0, e, rd);
            chk("abort_err", 32'(e), 32'd0, MALL);
            chk("abort_reload", rd, oldv, MALL);
        end

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // Random transactions against a byte-level memory model
        for (int s = 0; s < 3; s++) begin
            logic [31:0] exp_rd, mask;
            select(s);
            exp_rd = '0;
            mask = MALL;
            for (int t = 0; t < 40; t++) begin
                logic        w, exp_e;
                logic [1:0]  sz;
                logic [31:0] a, d;
                logic [3:0]  sb;
                int          wi;
                w  = 1'($urandom_range(0, 1));
                sz = 2'($urandom_range(0, 3));
                a  = ($urandom & 32'hFFFF_F000) | (32'h400 + 32'($urandom_range(0, 7)) * 4);
                if ($urandom_range(0, 2) == 0)  a[1:0] = 2'($urandom_range(0, 3));
                else if (sz == SIZE_H)          a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
                else if (sz == SIZE_B)          a[1:0] = 2'($urandom_range(0, 3));
                sb = 4'($urandom_range(0, 15));
                d  = $urandom;
                exp_e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
                wi = int'((a / 4) % NW);
                txn(w, sz, a, sb, d, e, rd);
                chk("rnd_err", 32'(e), 32'(exp_e), MALL);
                if (!exp_e && !w) begin
                    for (int b = 0; b < 4; b++) begin
                        exp_rd[8*b +: 8] = mdat[s][wi][b];
                        mask[8*b +: 8]   = mvld[s][wi][b] ? 8'hFF : 8'h00;
                    end
                end
                chk("rnd_rdata", rd, exp_rd, mask);
                if (!exp_e && w) begin
                    for (int b = 0; b < 4; b++) begin
                        if (sb[b]) begin
                            mdat[s][wi][b] = d[8*b +: 8];
                            mvld[s][wi][b] = 1'b1;
                        end
                    end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
